// File: rtl/common.sv
// Shared project-wide constants for the pipeline stage tops.
//
// Contents:
//   PIPELINE_FIFO_DEFAULT_DEPTH - entry count used when stage tops place a
//                                 pipeline_fifo between two stages.
package common;

   localparam int PIPELINE_FIFO_DEFAULT_DEPTH = 4;

endpackage : common

// File: rtl/pipeline_fifo_mem.sv
// Storage array for pipeline_fifo: DEPTH x DATA_WIDTH entries, one synchronous
// write port and one asynchronous (combinational) read port. Contents are not
// reset; occupancy tracking in the parent decides which entries are meaningful.
//
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, combinational from raddr
module pipeline_fifo_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // The head entry must be visible in the same cycle that m_valid is high,
   // so the read is combinational.
   assign rdata = mem[raddr];

endmodule : pipeline_fifo_mem

// File: rtl/pipeline_fifo.sv
// Flushable elastic buffer between two pipeline stages. A DEPTH-entry circular
// buffer with valid/ready on both sides; a one-cycle flush pulse discards all
// entries (e.g. on a taken branch).
//
// Optional feature macro: PIPELINE_FIFO_BYPASS_EN
//   When defined, an empty buffer forwards s_data to m_data combinationally.
//   If the consumer accepts in that cycle, the word is never stored.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous active-high reset
//   flush        in   synchronous discard of all entries (highest priority)
//   s_valid      in   producer has data
//   s_ready      out  buffer can accept (independent of m_ready)
//   s_data       in   producer payload
//   m_valid      out  head entry available
//   m_ready      in   consumer accepts
//   m_data       out  head payload
//   count        out  current occupancy
//   almost_full  out  count >= ALMOST_FULL_LEVEL
module pipeline_fifo
   import common::*;
#(
   parameter int DATA_WIDTH        = 32,
   parameter int DEPTH             = PIPELINE_FIFO_DEFAULT_DEPTH,
   parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_WIDTH-1:0]      s_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [DATA_WIDTH-1:0]      m_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_COUNT   = CNT_W'(ALMOST_FULL_LEVEL);

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      occupancy;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  stored_valid;
   logic                  push;
   logic                  pop;
   logic                  wr_en;

   pipeline_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (s_data),
      .raddr (rd_ptr),
      .rdata (head_data)
   );

   // Full is judged on stored occupancy alone, so a pop in the same cycle
   // never frees a slot early and m_ready has no path to s_ready.
   assign s_ready      = (occupancy != FULL_COUNT) && !flush && !rst;
   assign stored_valid = (occupancy != '0) && !flush;
   assign push         = s_valid && s_ready;
   assign pop          = stored_valid && m_ready && !rst;
   assign count        = occupancy;
   assign almost_full  = (occupancy >= AF_COUNT);

`ifdef PIPELINE_FIFO_BYPASS_EN
   logic bypass;

   assign bypass  = (occupancy == '0) && s_valid && !flush && !rst;
   assign m_valid = stored_valid || bypass;
   assign m_data  = bypass ? s_data : head_data;
   // A word consumed straight through the bypass is never written.
   assign wr_en   = push && !(bypass && m_ready);
`else
   assign m_valid = stored_valid;
   assign m_data  = head_data;
   assign wr_en   = push;
`endif

   // Pointers wrap by natural overflow; full/empty come from occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, pop})
            2'b10:   occupancy <= occupancy + CNT_W'(1);
            2'b01:   occupancy <= occupancy - CNT_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

endmodule : pipeline_fifo

// File: doc/pipeline_fifo.md
# pipeline_fifo

Parametrised, flushable elastic buffer placed between two pipeline stages. It decouples producer and consumer with a DEPTH-entry circular buffer and a valid/ready handshake. It discards all in-flight entries on a single-cycle `flush` pulse, for example on a taken branch. Stage tops wrap its flat ports onto their `Axis` links.

## Interface
- `DATA_WIDTH`, 32, payload width in bits (≥1).
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `ALMOST_FULL_LEVEL`, DEPTH-1, occupancy at or above which `almost_full` asserts; range 1..DEPTH.

- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous discard of all entries.
- `s_valid`  in  1  producer has data.
- `s_ready`  out  1  buffer can accept.
- `s_data`  in  DATA_WIDTH  producer payload.
- `m_valid`  out  1  head entry available.
- `m_ready`  in  1  consumer accepts.
- `m_data`  out  DATA_WIDTH  head payload.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `almost_full`  out  1  `count >= ALMOST_FULL_LEVEL`.

## Operation
- State consists of `wr_ptr` and `rd_ptr` (each $clog2(DEPTH) bits), `count`, and a storage array. Storage is not reset.
- Push occurs on `s_valid && s_ready`: `mem[wr_ptr] <= s_data`, then `wr_ptr` increments.
- Pop occurs on `m_valid && m_ready`: `rd_ptr` increments.
- Pointers wrap from DEPTH-1 to 0 by natural overflow. No extra wrap bit is used; full and empty come from `count`.
- `s_ready = (count != DEPTH) && !flush && !rst`.
  - It does not depend on `m_ready`.
  - When full, a same-cycle pop does not enable a push.
- `m_valid = (count != 0) && !flush`.
- `m_data = mem[rd_ptr]`. It is don't-care while `m_valid` is 0.
- Count update:
  - push and pop together: unchanged;
  - push only: +1;
  - pop only: -1.
- `count` never exceeds DEPTH and never underflows.
- Flush has the highest priority. In the flush cycle, `s_ready` and `m_valid` are forced to 0, so no handshake occurs on either side. At the next edge, `wr_ptr`, `rd_ptr` and `count` become 0.
- Flush on an already empty buffer has no effect.
- Reset values: `count` 0, both pointers 0, `m_valid` 0, `almost_full` 0, `s_ready` 0 while `rst` is high.
- Reset asserted mid-transfer drops every entry immediately. No handshake completes in a cycle where `rst` is high.

## Timing
- Latency without bypass: data pushed at edge N is presented with `m_valid`=1 in the cycle after edge N.
- Sustained throughput is one transfer per cycle when DEPTH ≥ 2 and the consumer is always ready.
- `count`, `almost_full`, `s_ready` and `m_valid` are combinational functions of registered state, `flush` and `rst` only. There is no combinational path from `m_ready` to `s_ready`.
- A producer blocked by full sees `s_ready` rise in the cycle after the first pop.

## Configuration
- `PIPELINE_FIFO_BYPASS_EN`
  - Defined: when `count == 0`, `s_valid` is high and `flush` is low, then `m_valid = 1` and `m_data = s_data` combinationally.
    - If `m_ready` is also high, the word passes through with zero latency. It is not written, and pointers and `count` are unchanged.
    - If `m_ready` is low, the word is stored normally.
    - This adds a combinational path from `s_valid`/`s_data` to `m_valid`/`m_data`.
  - Undefined: there is no input-to-output combinational path, and latency is exactly one cycle.

## Structure
- Add `PIPELINE_FIFO_DEFAULT_DEPTH` (=4) to package `common`. Stage tops use it when instantiating.
- No new typedefs are needed. The payload is a plain `logic [DATA_WIDTH-1:0]`; callers pack `fetch_to_decode_t` and similar structs into it.
- One sub-module: `pipeline_fifo_mem`, a DEPTH×DATA_WIDTH array with one write port and one asynchronous read port, no reset.

## Test plan
- Fill from reset with DEPTH=4 and `m_ready`=0: push 0xA0..0xA3 → `count` rises 1..4, `almost_full` asserts at `count`=3, `s_ready`=0 at 4, and a fifth push is not accepted.
- Drain: from full, assert `m_ready`=1 → `m_data` reads 0xA0, 0xA1, 0xA2, 0xA3 in order, `m_valid` drops after the fourth pop, and `count` returns to 0.
- Wrap and streaming: continuous push and pop of 0..19 with `m_ready`=1 → output sequence 0..19 with no gaps after first valid, and `count` stays at 1 in steady state (0 with bypass).
- Flush: with 3 entries and a simultaneous `s_valid`, pulse `flush` → no handshake in that cycle, `count`=0 and `m_valid`=0 next cycle, and the next push of 0x55 emerges first.
- Async reset: assert `rst` between edges with 2 entries → `count`, `m_valid` and `s_ready` go to 0 without waiting for an edge, and the buffer is empty after release.
- Bypass (macro defined): empty buffer with `s_valid`=1, `s_data`=0x77 and `m_ready`=1 → `m_valid`=1 and `m_data`=0x77 in the same cycle, `count` stays 0. With `m_ready`=0, `count`=1 next cycle.
